day08_pair_scheduler: RTL and testbench
=======================================

Name: day08_pair_scheduler

Overview:
- Upstream feeder for the day-08 distance/sort/union-find pipeline.
- Captures a point list through a load handshake into a register-based point store.
- Then streams every reference line as BATCH_SIZE-wide beats (batch_coords/batch_indices/batch_valid/batch_line_end/batch_stream_end) into the downstream top.
- Slot 0 of each line's first beat is the reference point; a line for reference i carries points i..N-1, so every unordered pair appears exactly once. The self-pair is filtered downstream.

Parameters:
- MAX_NODE_COUNT, 10, capacity of the point store.
- INDEX_BIT_WIDTH, $clog2(MAX_NODE_COUNT), localparam, index width.
- COORD_BIT_WIDTH, 32, width of one coordinate.
- DIMENSIONS, 3, coordinates per point.
- BATCH_SIZE, 2, points per output beat.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- load_valid  in  1  load_coord holds a point
- load_ready  out  1  store accepts a point this cycle
- load_coord  in  [COORD_BIT_WIDTH-1:0][0:DIMENSIONS-1]  point coordinates
- load_last  in  1  final point of the list
- in_ready  in  1  downstream accepts the presented beat
- batch_coords  out  [COORD_BIT_WIDTH-1:0][0:BATCH_SIZE-1][0:DIMENSIONS-1]  beat coordinates
- batch_indices  out  [INDEX_BIT_WIDTH-1:0][0:BATCH_SIZE-1]  point index per slot
- batch_valid  out  BATCH_SIZE  per-slot valid; a beat is presented iff |batch_valid
- batch_line_end  out  1  last beat of the current reference line
- batch_stream_end  out  1  last beat of the whole stream
- node_count  out  INDEX_BIT_WIDTH+1  number of points loaded
- done  out  1  stream fully accepted

Behaviour:
- Reset (async assert, clk-synchronous deassert): state LOAD, node_count=0, batch_valid=0, batch_line_end=0, batch_stream_end=0, done=0, load_ready=1. batch_coords/batch_indices reset to 0.
- FSM LOAD -> STREAM -> DONE. DONE is held until the next reset.
- LOAD state:
  - load_ready=1. On load_valid&&load_ready, write the point to slot node_count and increment node_count.
  - If load_last is set, or the write fills slot MAX_NODE_COUNT-1 (forced last), go to STREAM with ref=0, cur=0. load_ready goes to 0 the next cycle.
  - Loads of more than MAX_NODE_COUNT points are impossible: the forced last ends the load.
- STREAM state:
  - Outputs are registered. The first beat is presented one cycle after the last load handshake.
  - Beat contents: slot k = point cur+k with index cur+k. batch_valid[k] = (cur+k < N).
  - Handshake: a beat is accepted when |batch_valid && in_ready. While in_ready=0, all batch_* outputs hold stable.
  - On acceptance:
    - If cur+BATCH_SIZE >= N, the beat was line-end: ref<=ref+1, cur<=ref+1.
    - Otherwise cur<=cur+BATCH_SIZE.
    - The next beat is presented the following cycle (one beat per cycle at full throughput).
  - batch_line_end=1 on every beat where cur+BATCH_SIZE >= N.
  - batch_stream_end=1 on the line-end beat of ref=N-2.
  - Special case N=1: one beat, slot0=point 0, line_end=stream_end=1.
  - After the stream_end beat is accepted, batch_valid=0, line_end=0, stream_end=0, and the FSM goes to DONE.
- DONE: done=1, load_ready=0, no beats.
- Arithmetic: cur+k and comparisons against N are computed at INDEX_BIT_WIDTH+1 bits so there is no wrap at MAX_NODE_COUNT.
- Reset mid-load or mid-stream: immediate return to reset values; stored points are discarded (node_count=0).
- load_valid during STREAM/DONE: ignored.

Optional Feature:
- Macro DAY08_PAIR_SCHED_STATS_EN.
- Defined: adds output beat_count (16 bits), which increments on each accepted beat, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter are absent.

Decomposition:
- day08_pkg holds:
  - coordinate typedef coord_t (logic [COORD_BIT_WIDTH-1:0]);
  - point_t (coord_t array of DIMENSIONS);
  - state enum {LOAD, STREAM, DONE}.
- One sub-module, day08_point_store: register array with one write port and BATCH_SIZE combinational read ports. An out-of-range read returns 0.

Test Plan:
- N=3, B=2, in_ready=1 -> beats:
  - [0,1] valid=11;
  - [2,x] valid=01, line_end=1;
  - [1,2] valid=11, line_end=1, stream_end=1;
  - then done=1.
- N=10, B=2, in_ready=1 -> 29 beats, 9 line_ends, 45 distinct (u<v) pairs plus 9 self pairs, stream_end only on beat 29.
- Same N=3 stream with in_ready toggling 1/0 each cycle -> identical beat sequence; outputs stable during every stall cycle.
- Load 12 points with MAX_NODE_COUNT=10, no load_last -> node_count=10, load_ready=0 after the 10th, stream matches the N=10 case.
- N=1 -> single beat, slot0 index 0, valid=01, line_end=stream_end=1, then done.
- rst_n low during the 2nd beat of N=3 -> all outputs zero asynchronously. Reload with N=2 -> single beat [0,1] valid=11, line_end=stream_end=1.

Source files
------------

// File: rtl/day08_pkg.sv
// ============================================================================
//  Module      : day08_pkg
//  Description : Shared types for the day-08 pair scheduler: coordinate and
//                point types plus the scheduler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package day08_pkg;

    localparam int DAY08_COORD_BIT_WIDTH = 32;
    localparam int DAY08_DIMENSIONS      = 3;

    typedef logic [DAY08_COORD_BIT_WIDTH-1:0] coord_t;
    typedef coord_t [0:DAY08_DIMENSIONS-1]    point_t;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage : day08_pkg

`default_nettype wire

// File: rtl/day08_point_store.sv
// ============================================================================
//  Module      : day08_point_store
//  Description : Register-based point store. One synchronous write port and
//                READ_PORTS combinational read ports. A read address at or
//                beyond DEPTH returns all zeros.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                wr_en/addr/data - write port
//                rd_addr/rd_data - combinational read ports (one extra
//                                  address bit so callers need not clamp)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module day08_point_store #(
    parameter int  DEPTH           = 10,
    parameter int  COORD_BIT_WIDTH = 32,
    parameter int  DIMENSIONS      = 3,
    parameter int  READ_PORTS      = 2,
    localparam int AW              = $clog2(DEPTH),
    localparam int RAW             = AW + 1
) (
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  wr_en,
    input  logic [AW-1:0]                                         wr_addr,
    input  logic [0:DIMENSIONS-1][COORD_BIT_WIDTH-1:0]            wr_data,
    input  logic [0:READ_PORTS-1][RAW-1:0]                        rd_addr,
    output logic [0:READ_PORTS-1][0:DIMENSIONS-1][COORD_BIT_WIDTH-1:0] rd_data
);

    logic [0:DIMENSIONS-1][COORD_BIT_WIDTH-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
        assign rd_data[g] = (rd_addr[g] < RAW'(DEPTH)) ? r_mem[rd_addr[g][AW-1:0]] : '0;
    end

endmodule : day08_point_store

`default_nettype wire

// File: rtl/day08_pair_scheduler.sv
// ============================================================================
//  Module      : day08_pair_scheduler
//  Description : Loads a point list through a valid/ready handshake, then
//                streams, for every reference point i, the points i..N-1 as
//                BATCH_SIZE-wide beats so each unordered pair appears once
//                (the self pair in slot 0 is filtered downstream).
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                load_valid/ready/coord/last - point load handshake
//                in_ready                    - downstream beat acceptance
//                batch_*                     - registered output beat
//                node_count                  - number of points loaded
//                done                        - whole stream accepted
//                beat_count                  - accepted beats (stats build)
//  Options     : DAY08_PAIR_SCHED_STATS_EN adds the saturating 16-bit
//                beat_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module day08_pair_scheduler
    import day08_pkg::*;
#(
    parameter int  MAX_NODE_COUNT  = 10,
    parameter int  COORD_BIT_WIDTH = DAY08_COORD_BIT_WIDTH,
    parameter int  DIMENSIONS      = DAY08_DIMENSIONS,
    parameter int  BATCH_SIZE      = 2,
    localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT)
) (
    input  logic                                                       clk,
    input  logic                                                       rst_n,
    input  logic                                                       load_valid,
    output logic                                                       load_ready,
    input  logic [0:DIMENSIONS-1][COORD_BIT_WIDTH-1:0]                 load_coord,
    input  logic                                                       load_last,
    input  logic                                                       in_ready,
    output logic [0:BATCH_SIZE-1][0:DIMENSIONS-1][COORD_BIT_WIDTH-1:0] batch_coords,
    output logic [0:BATCH_SIZE-1][INDEX_BIT_WIDTH-1:0]                 batch_indices,
    output logic [BATCH_SIZE-1:0]                                      batch_valid,
    output logic                                                       batch_line_end,
    output logic                                                       batch_stream_end,
    output logic [INDEX_BIT_WIDTH:0]                                   node_count,
    output logic                                                       done
`ifdef DAY08_PAIR_SCHED_STATS_EN
    ,
    output logic [15:0]                                                beat_count
`endif
);

    // Counters and comparisons carry one extra bit so cur+k never wraps at
    // MAX_NODE_COUNT.
    localparam int                 C_CNT_W     = INDEX_BIT_WIDTH + 1;
    localparam logic [C_CNT_W-1:0] C_LAST_SLOT = C_CNT_W'(MAX_NODE_COUNT - 1);
    localparam logic [C_CNT_W-1:0] C_BATCH     = C_CNT_W'(BATCH_SIZE);
    localparam logic [C_CNT_W-1:0] C_TWO       = C_CNT_W'(2);

    state_t                                                     r_state;
    state_t                                                     w_state_nxt;
    logic [C_CNT_W-1:0]                                         r_node_count;
    logic [C_CNT_W-1:0]                                         w_count_nxt;
    logic [C_CNT_W-1:0]                                         r_ref;
    logic [C_CNT_W-1:0]                                         w_ref_nxt;
    logic [C_CNT_W-1:0]                                         r_cur;
    logic [C_CNT_W-1:0]                                         w_cur_nxt;
    logic [C_CNT_W-1:0]                                         w_n_eff;
    logic                                                       w_wr_en;
    logic                                                       w_present;
    logic                                                       w_clear;
    logic                                                       w_accept;

    logic [0:BATCH_SIZE-1][C_CNT_W-1:0]                         w_rd_addr;
    logic [0:BATCH_SIZE-1][0:DIMENSIONS-1][COORD_BIT_WIDTH-1:0] w_store_data;
    logic [0:BATCH_SIZE-1][0:DIMENSIONS-1][COORD_BIT_WIDTH-1:0] w_slot_coords;
    logic [0:BATCH_SIZE-1][INDEX_BIT_WIDTH-1:0]                 w_slot_index;
    logic [BATCH_SIZE-1:0]                                      w_slot_valid;
    logic                                                       w_line_end;
    logic                                                       w_stream_end;

    logic [0:BATCH_SIZE-1][0:DIMENSIONS-1][COORD_BIT_WIDTH-1:0] r_batch_coords;
    logic [0:BATCH_SIZE-1][INDEX_BIT_WIDTH-1:0]                 r_batch_indices;
    logic [BATCH_SIZE-1:0]                                      r_batch_valid;
    logic                                                       r_batch_line_end;
    logic                                                       r_batch_stream_end;

    assign w_accept = (r_state == STREAM) && (|r_batch_valid) && in_ready;

    // ------------------------------------------------------------------------
    // Next-state logic. The output beat is registered, so the beat for the
    // next (cur, ref) is built combinationally and captured whenever
    // w_present is set: on the final load handshake and on each acceptance
    // that is not the stream end.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_node_count;
        w_ref_nxt   = r_ref;
        w_cur_nxt   = r_cur;
        w_n_eff     = r_node_count;
        w_wr_en     = 1'b0;
        w_present   = 1'b0;
        w_clear     = 1'b0;

        case (r_state)
            LOAD: begin
                if (load_valid) begin
                    w_wr_en     = 1'b1;
                    w_count_nxt = r_node_count + 1'b1;
                    // Filling the last slot ends the load even without load_last.
                    if (load_last || (r_node_count == C_LAST_SLOT)) begin
                        w_state_nxt = STREAM;
                        w_ref_nxt   = '0;
                        w_cur_nxt   = '0;
                        w_n_eff     = r_node_count + 1'b1;
                        w_present   = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (w_accept) begin
                    if (r_batch_stream_end) begin
                        w_state_nxt = DONE;
                        w_clear     = 1'b1;
                    end else begin
                        if (r_batch_line_end) begin
                            w_ref_nxt = r_ref + 1'b1;
                            w_cur_nxt = r_ref + 1'b1;
                        end else begin
                            w_cur_nxt = r_cur + C_BATCH;
                        end
                        w_present = 1'b1;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    day08_point_store #(
        .DEPTH           (MAX_NODE_COUNT),
        .COORD_BIT_WIDTH (COORD_BIT_WIDTH),
        .DIMENSIONS      (DIMENSIONS),
        .READ_PORTS      (BATCH_SIZE)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_wr_en),
        .wr_addr (r_node_count[INDEX_BIT_WIDTH-1:0]),
        .wr_data (load_coord),
        .rd_addr (w_rd_addr),
        .rd_data (w_store_data)
    );

    // Beat construction. The first beat is built in the same cycle the last
    // point is written, so a read of that slot takes the incoming load data.
    for (genvar g = 0; g < BATCH_SIZE; g++) begin : g_slot
        assign w_rd_addr[g]     = w_cur_nxt + C_CNT_W'(g);
        assign w_slot_coords[g] = (w_wr_en && (w_rd_addr[g] == r_node_count)) ?
                                  load_coord : w_store_data[g];
        assign w_slot_valid[g]  = (w_rd_addr[g] < w_n_eff);
        assign w_slot_index[g]  = w_rd_addr[g][INDEX_BIT_WIDTH-1:0];
    end

    assign w_line_end   = ((w_cur_nxt + C_BATCH) >= w_n_eff);
    // Last line is ref = N-2; for N=1 the single line (ref 0) also ends it.
    assign w_stream_end = w_line_end && ((w_ref_nxt + C_TWO) >= w_n_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= LOAD;
            r_node_count       <= '0;
            r_ref              <= '0;
            r_cur              <= '0;
            r_batch_coords     <= '0;
            r_batch_indices    <= '0;
            r_batch_valid      <= '0;
            r_batch_line_end   <= 1'b0;
            r_batch_stream_end <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_node_count <= w_count_nxt;
            r_ref        <= w_ref_nxt;
            r_cur        <= w_cur_nxt;
            if (w_present) begin
                r_batch_coords     <= w_slot_coords;
                r_batch_indices    <= w_slot_index;
                r_batch_valid      <= w_slot_valid;
                r_batch_line_end   <= w_line_end;
                r_batch_stream_end <= w_stream_end;
            end else if (w_clear) begin
                r_batch_valid      <= '0;
                r_batch_line_end   <= 1'b0;
                r_batch_stream_end <= 1'b0;
            end
        end
    end

    assign load_ready       = (r_state == LOAD);
    assign done             = (r_state == DONE);
    assign node_count       = r_node_count;
    assign batch_coords     = r_batch_coords;
    assign batch_indices    = r_batch_indices;
    assign batch_valid      = r_batch_valid;
    assign batch_line_end   = r_batch_line_end;
    assign batch_stream_end = r_batch_stream_end;

`ifdef DAY08_PAIR_SCHED_STATS_EN
    logic [15:0] r_beat_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_count <= '0;
        end else if (w_accept && (r_beat_count != 16'hFFFF)) begin
            r_beat_count <= r_beat_count + 16'd1;
        end
    end

    assign beat_count = r_beat_count;
`endif

endmodule : day08_pair_scheduler

`default_nettype wire

// File: tb/tb_day08_pair_scheduler.sv
// ============================================================================
//  Module      : tb_day08_pair_scheduler
//  Description : Directed self-checking bench for day08_pair_scheduler with
//                default parameters (MAX_NODE_COUNT=10, BATCH_SIZE=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_day08_pair_scheduler;

    typedef logic [0:2][31:0] pt_t;

    typedef struct {
        int         i0;
        int         i1;
        logic [1:0] v;
        logic       le;
        logic       se;
    } beat_t;

    logic               clk;
    logic               rst_n;
    logic               load_valid;
    logic               load_ready;
    pt_t                load_coord;
    logic               load_last;
    logic               in_ready;
    logic [0:1][0:2][31:0] batch_coords;
    logic [0:1][3:0]    batch_indices;
    logic [1:0]         batch_valid;
    logic               batch_line_end;
    logic               batch_stream_end;
    logic [4:0]         node_count;
    logic               done;

    int checks = 0;
    int errors = 0;

    beat_t exp_q[$];
    int    g_beats, g_line_ends, g_se_count, g_se_beat;
    int    g_pairs, g_selfs, g_dups, g_bad;
    bit    seen [16][16];

    day08_pair_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_valid       (load_valid),
        .load_ready       (load_ready),
        .load_coord       (load_coord),
        .load_last        (load_last),
        .in_ready         (in_ready),
        .batch_coords     (batch_coords),
        .batch_indices    (batch_indices),
        .batch_valid      (batch_valid),
        .batch_line_end   (batch_line_end),
        .batch_stream_end (batch_stream_end),
        .node_count       (node_count),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic pt_t pt(input int i);
        pt_t p;
        for (int d = 0; d < 3; d++) begin
            p[d] = 32'(i * 1000 + d * 7 + 5);
        end
        return p;
    endfunction

    // Expected beats, enumerated directly from the line/beat definition.
    function automatic void build_expected(input int n);
        beat_t b;
        exp_q.delete();
        if (n == 1) begin
            b.i0 = 0; b.i1 = 1; b.v = 2'b01; b.le = 1'b1; b.se = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int r = 0; r <= n - 2; r++) begin
                int c;
                c = r;
                while (1) begin
                    b.i0   = c;
                    b.i1   = c + 1;
                    b.v[0] = (c < n);
                    b.v[1] = (c + 1 < n);
                    b.le   = (c + 2 >= n);
                    b.se   = b.le && (r == n - 2);
                    exp_q.push_back(b);
                    if (b.le) break;
                    c = c + 2;
                end
            end
        end
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        in_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives n points back to back; load_ready expected high for the first
    // ten offers and low afterwards. in_ready is held low meanwhile.
    task automatic load_points(input int n, input bit with_last);
        logic exp_rdy;
        in_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_coord = pt(i);
            load_last  = with_last && (i == n - 1);
            exp_rdy    = (i < 10);
            checks++;
            if (load_ready !== exp_rdy) begin
                errors++;
                $display("FAIL load_ready[%0d]: got %b expected %b", i, load_ready, exp_rdy);
            end
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic run_stream(input int n, input bit stall);
        beat_t                 e;
        int                    got, cyc, cur_ref, v;
        bit                    held, tog, new_line;
        logic [0:1][3:0]       s_idx;
        logic [1:0]            s_v;
        logic                  s_le, s_se;
        logic [0:1][0:2][31:0] s_c;

        build_expected(n);
        g_beats = 0; g_line_ends = 0; g_se_count = 0; g_se_beat = 0;
        g_pairs = 0; g_selfs = 0; g_dups = 0; g_bad = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                seen[a][b] = 1'b0;

        checks++;
        if ((|batch_valid) !== 1'b1) begin
            errors++;
            $display("FAIL first_beat_latency n=%0d: batch_valid=%b expected nonzero", n, batch_valid);
        end

        got = 0; cyc = 0; held = 1'b0; tog = 1'b0; new_line = 1'b1; cur_ref = 0;
        s_idx = '0; s_v = '0; s_le = 1'b0; s_se = 1'b0; s_c = '0;
        while (got < exp_q.size() && cyc < 400) begin
            tog      = ~tog;
            in_ready = stall ? tog : 1'b1;
            if (|batch_valid) begin
                if (held) begin
                    checks++;
                    if ({batch_indices, batch_valid, batch_line_end, batch_stream_end, batch_coords}
                        !== {s_idx, s_v, s_le, s_se, s_c}) begin
                        errors++;
                        $display("FAIL stall_hold n=%0d beat %0d: got idx=%0d,%0d v=%b le=%b se=%b, expected idx=%0d,%0d v=%b le=%b se=%b",
                                 n, got, batch_indices[0], batch_indices[1], batch_valid,
                                 batch_line_end, batch_stream_end, s_idx[0], s_idx[1], s_v, s_le, s_se);
                    end
                end
                if (in_ready) begin
                    e = exp_q[got];
                    checks++;
                    if ({batch_indices[0], batch_indices[1], batch_valid, batch_line_end, batch_stream_end}
                        !== {4'(e.i0), 4'(e.i1), e.v, e.le, e.se}) begin
                        errors++;
                        $display("FAIL beat n=%0d #%0d: got idx=%0d,%0d v=%b le=%b se=%b, expected idx=%0d,%0d v=%b le=%b se=%b",
                                 n, got, batch_indices[0], batch_indices[1], batch_valid,
                                 batch_line_end, batch_stream_end, e.i0, e.i1, e.v, e.le, e.se);
                    end
                    for (int k = 0; k < 2; k++) begin
                        if (e.v[k]) begin
                            checks++;
                            if (batch_coords[k] !== pt(e.i0 + k)) begin
                                errors++;
                                $display("FAIL coords n=%0d #%0d slot%0d: got %h expected %h",
                                         n, got, k, batch_coords[k], pt(e.i0 + k));
                            end
                        end
                    end
                    // Pair bookkeeping from observed outputs.
                    g_beats++;
                    if (new_line) cur_ref = int'(batch_indices[0]);
                    for (int k = 0; k < 2; k++) begin
                        if (batch_valid[k]) begin
                            v = int'(batch_indices[k]);
                            if (v == cur_ref) g_selfs++;
                            else if (v > cur_ref) begin
                                if (seen[cur_ref][v]) g_dups++;
                                else begin
                                    seen[cur_ref][v] = 1'b1;
                                    g_pairs++;
                                end
                            end else g_bad++;
                        end
                    end
                    new_line = batch_line_end;
                    if (batch_line_end) g_line_ends++;
                    if (batch_stream_end) begin
                        g_se_count++;
                        g_se_beat = g_beats;
                    end
                    got++;
                end
                s_idx = batch_indices; s_v = batch_valid; s_le = batch_line_end;
                s_se  = batch_stream_end; s_c = batch_coords;
                held  = !in_ready;
            end else begin
                held = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_ready = 1'b0;

        checks++;
        if (got != exp_q.size()) begin
            errors++;
            $display("FAIL stream_timeout n=%0d: accepted %0d beats expected %0d", n, got, exp_q.size());
        end
        checks++;
        if ({done, batch_valid, batch_line_end, batch_stream_end} !== 5'b1_00_0_0) begin
            errors++;
            $display("FAIL end_state n=%0d: got done=%b v=%b le=%b se=%b expected done=1 v=00 le=0 se=0",
                     n, done, batch_valid, batch_line_end, batch_stream_end);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({load_ready, done, batch_valid, batch_line_end, batch_stream_end, node_count}
            !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b done=%b v=%b le=%b se=%b cnt=%0d expected rdy=1 rest 0",
                     load_ready, done, batch_valid, batch_line_end, batch_stream_end, node_count);
        end
        checks++;
        if ({batch_coords, batch_indices} !== '0) begin
            errors++;
            $display("FAIL reset_data: got idx=%h expected 0", batch_indices);
        end
        do_reset();
        checks++;
        if ({load_ready, done, node_count} !== {1'b1, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL post_reset_idle: got rdy=%b done=%b cnt=%0d expected 1 0 0",
                     load_ready, done, node_count);
        end
    endtask

    task automatic test_n3_basic();
        do_reset();
        load_points(3, 1'b1);
        checks++;
        if ({load_ready, node_count} !== {1'b0, 5'd3}) begin
            errors++;
            $display("FAIL n3_load_end: got rdy=%b cnt=%0d expected 0 3", load_ready, node_count);
        end
        run_stream(3, 1'b0);
        // DONE persists and ignores further loads.
        load_valid = 1'b1;
        load_coord = pt(7);
        repeat (3) @(posedge clk);
        #1;
        load_valid = 1'b0;
        checks++;
        if ({done, load_ready, node_count, batch_valid} !== {1'b1, 1'b0, 5'd3, 2'b00}) begin
            errors++;
            $display("FAIL done_hold: got done=%b rdy=%b cnt=%0d v=%b expected 1 0 3 00",
                     done, load_ready, node_count, batch_valid);
        end
    endtask

    task automatic test_n10_full();
        do_reset();
        load_points(10, 1'b1);
        checks++;
        if (node_count !== 5'd10) begin
            errors++;
            $display("FAIL n10_count: got %0d expected 10", node_count);
        end
        run_stream(10, 1'b0);
        checks++;
        if ({g_beats, g_line_ends, g_se_count, g_se_beat} !== {32'd29, 32'd9, 32'd1, 32'd29}) begin
            errors++;
            $display("FAIL n10_shape: got beats=%0d line_ends=%0d se=%0d se_beat=%0d expected 29 9 1 29",
                     g_beats, g_line_ends, g_se_count, g_se_beat);
        end
        checks++;
        if ({g_pairs, g_selfs, g_dups, g_bad} !== {32'd45, 32'd9, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL n10_pairs: got pairs=%0d selfs=%0d dups=%0d bad=%0d expected 45 9 0 0",
                     g_pairs, g_selfs, g_dups, g_bad);
        end
    endtask

    task automatic test_n3_stall();
        do_reset();
        load_points(3, 1'b1);
        run_stream(3, 1'b1);
    endtask

    task automatic test_overload();
        do_reset();
        load_points(12, 1'b0);
        checks++;
        if ({node_count, load_ready} !== {5'd10, 1'b0}) begin
            errors++;
            $display("FAIL overload_count: got cnt=%0d rdy=%b expected 10 0", node_count, load_ready);
        end
        run_stream(10, 1'b0);
        checks++;
        if ({g_beats, g_pairs} !== {32'd29, 32'd45}) begin
            errors++;
            $display("FAIL overload_stream: got beats=%0d pairs=%0d expected 29 45", g_beats, g_pairs);
        end
    endtask

    task automatic test_n1();
        do_reset();
        load_points(1, 1'b1);
        run_stream(1, 1'b0);
    endtask

    task automatic test_reset_midstream();
        do_reset();
        load_points(3, 1'b1);
        in_ready = 1'b1;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        checks++;
        if ({batch_indices[0], batch_valid} !== {4'd2, 2'b01}) begin
            errors++;
            $display("FAIL mid_second_beat: got idx0=%0d v=%b expected 2 01", batch_indices[0], batch_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({batch_coords, batch_indices, batch_valid, batch_line_end, batch_stream_end, done, node_count}
            !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b le=%b se=%b done=%b cnt=%0d idx=%h expected all 0",
                     batch_valid, batch_line_end, batch_stream_end, done, node_count, batch_indices);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        load_points(2, 1'b1);
        run_stream(2, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_coord = '0;
        in_ready   = 1'b0;

        test_reset();
        test_n3_basic();
        test_n10_full();
        test_n3_stall();
        test_overload();
        test_n1();
        test_reset_midstream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_day08_pair_scheduler

`default_nettype wire
